// File: rtl/spi_frame_arbiter_pkg.sv
// Shared types for the SPI frame arbiter.
// The gap state is only reachable when SPI_ARB_GAP_EN is defined.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Width of the inter-frame gap counter; bounds GAP_CYCLES to 1..255.
    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/spi_frame_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the SPI master.
// The slave modport is the arbiter. The master modport is the environment:
// it drives the requester side and sinks the SPI side.
interface spi_frame_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0][7:0] req_wdata;
    logic [N_REQ-1:0]      req_wvalid;
    logic [N_REQ-1:0]      req_wlast;
    logic [N_REQ-1:0]      req_wready;
    logic [7:0]            out_wdata;
    logic                  out_wvalid;
    logic                  out_wlast;
    logic                  out_wready;

    modport slave (
        input  req_wdata, req_wvalid, req_wlast, out_wready,
        output req_wready, out_wdata, out_wvalid, out_wlast
    );

    modport master (
        output req_wdata, req_wvalid, req_wlast, out_wready,
        input  req_wready, out_wdata, out_wvalid, out_wlast
    );
endinterface

// File: rtl/spi_frame_arbiter_rr_pick.sv
// Combinational round-robin selector.
// It returns the first requesting index at or after ptr, wrapping modulo N.
// ptr must be below N.
module spi_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a single SPI byte-stream master.
// A grant is held from the first byte of a frame through its wlast handshake.
// Build option SPI_ARB_GAP_EN adds a GAP_CYCLES idle countdown after each frame.
module spi_frame_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int GAP_CYCLES = 8,
    localparam int GID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_frame_arbiter_if.slave     bus,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy
);

    if (N_REQ < 1 || N_REQ > 16) begin : g_bad_n_req
        $error("spi_frame_arbiter: N_REQ must be 1..16");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > (1 << GAP_CNT_W) - 1) begin : g_bad_gap
        $error("spi_frame_arbiter: GAP_CYCLES must be 1..255");
    end

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [GID_W-1:0] rr_ptr;
    logic             pick_found;
    logic [GID_W-1:0] pick_idx;
    logic             frame_end;

    spi_rr_pick #(
        .N (N_REQ),
        .W (GID_W)
    ) u_pick (
        .req   (bus.req_wvalid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign frame_end = (state == ST_XFER) && bus.out_wvalid && bus.out_wready && bus.out_wlast;

`ifdef SPI_ARB_GAP_EN
    logic [GAP_CNT_W-1:0] gap_cnt;

    // Gap countdown: loaded at frame end, decremented while in the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (frame_end) begin
            gap_cnt <= GAP_CNT_W'(GAP_CYCLES);
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end
`endif

    // State register; busy is registered from the next state so it matches the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state logic: grant on any request, release on the wlast handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (frame_end) begin
`ifdef SPI_ARB_GAP_EN
                    state_nxt = ST_GAP;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef SPI_ARB_GAP_EN
            ST_GAP: begin
                if (gap_cnt == GAP_CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant index is captured at the pick; the pointer moves past the owner at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            if (state == ST_IDLE && pick_found) begin
                grant_id <= pick_idx;
            end
            if (frame_end) begin
                rr_ptr <= (grant_id == GID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Output mux and ready demux: only the granted requester sees the SPI ready.
    always_comb begin
        bus.out_wdata  = '0;
        bus.out_wvalid = 1'b0;
        bus.out_wlast  = 1'b0;
        bus.req_wready = '0;
        if (state == ST_XFER) begin
            bus.out_wdata            = bus.req_wdata[grant_id];
            bus.out_wvalid           = bus.req_wvalid[grant_id];
            bus.out_wlast            = bus.req_wlast[grant_id];
            bus.req_wready[grant_id] = bus.out_wready;
        end
    end

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Testbench for spi_frame_arbiter. It adapts to SPI_ARB_GAP_EN.
// Requester drivers replay per-requester byte queues.
// A frame-level round-robin reference predicts every output handshake and the
// per-cycle status. A monitor process compares the DUT against those predictions.
module tb_spi_frame_arbiter;

    localparam int N = 4;
    localparam int G = 5;
`ifdef SPI_ARB_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    typedef struct packed {
        logic [7:0] hold;
        logic       last;
        logic [7:0] data;
    } ent_t;

    typedef struct {
        int cyc;
        int data;
        int last;
    } tx_t;

    typedef struct {
        int busy;
        int vld;
        int gid;
        int rdy;
    } st_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] grant_id;
    logic       busy;

    spi_frame_arbiter_if #(.N_REQ(N)) bus ();

    spi_frame_arbiter #(
        .N_REQ      (N),
        .GAP_CYCLES (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    ent_t       fq [N][$];
    tx_t        tx_q [$];
    st_t        st_q [$];
    bit         rdy_q [$];
    bit [N-1:0] vld;
    bit [N-1:0] lst;
    logic [7:0] dat [N];
    int         hold [N];
    bit         armed [N];
    bit [N-1:0] hs;
    bit         rdy;
    int         rdy_pct;
    int         cyc;
    int         n_chk;
    int         n_pass;

    int m_owner;
    int m_gap;
    int m_ptr;
    int m_gid;

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_bus();
        bus.req_wvalid = vld;
        bus.req_wlast  = lst;
        for (int i = 0; i < N; i++) bus.req_wdata[i] = dat[i];
        bus.out_wready = rdy;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            fq[i].delete();
            dat[i]   = 8'h00;
            hold[i]  = 0;
            armed[i] = 1'b0;
        end
        vld = '0;
        lst = '0;
        hs  = '0;
        rdy_q.delete();
        push_bus();
    endtask

    task automatic model_reset();
        tx_q.delete();
        st_q.delete();
        m_owner = -1;
        m_gap   = 0;
        m_ptr   = 0;
        m_gid   = 0;
    endtask

    task automatic add_byte(int r, logic [7:0] d, bit l, int h);
        ent_t e;
        e.data = d;
        e.last = l;
        e.hold = 8'(h);
        fq[r].push_back(e);
    endtask

    task automatic add_random_frame(int r);
        int len;
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
            add_byte(r, 8'($urandom_range(255)), (b == len - 1),
                     ($urandom_range(3) == 0) ? $urandom_range(1, 4) : 0);
    endtask

    // Requester drivers: advance on a handshake, honour per-byte valid-low holds.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hs[i] && fq[i].size() > 0) begin
                void'(fq[i].pop_front());
                armed[i] = 1'b0;
            end
            if (fq[i].size() > 0 && !armed[i]) begin
                hold[i]  = int'(fq[i][0].hold);
                armed[i] = 1'b1;
            end
            if (fq[i].size() > 0 && hold[i] == 0) begin
                vld[i] = 1'b1;
                dat[i] = fq[i][0].data;
                lst[i] = fq[i][0].last;
            end else begin
                vld[i] = 1'b0;
                lst[i] = 1'b0;
                if (hold[i] > 0) hold[i]--;
            end
        end
        if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
        else if (rdy_pct == 0) rdy = 1'b1;
        else rdy = ($urandom_range(99) >= rdy_pct);
        push_bus();
    endtask

    // Reference: one frame owner at a time, round-robin from the pointer, then an optional gap.
    task automatic model_cycle();
        st_t s;
        tx_t t;
        s.busy = (m_owner >= 0 || m_gap > 0) ? 1 : 0;
        s.vld  = (m_owner >= 0) ? int'(vld[m_owner]) : 0;
        s.gid  = m_gid;
        s.rdy  = (m_owner >= 0 && rdy) ? (1 << m_owner) : 0;
        st_q.push_back(s);
        if (m_owner >= 0) begin
            if (vld[m_owner] && rdy) begin
                t.cyc  = cyc;
                t.data = int'(dat[m_owner]);
                t.last = int'(lst[m_owner]);
                tx_q.push_back(t);
                if (lst[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = GAP_EN ? G : 0;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_owner < 0 && vld[j]) begin
                    m_owner = j;
                    m_gid   = j;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        model_cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) hs[i] = bus.req_wvalid[i] && bus.req_wready[i];
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_drain(string name, int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(all_empty() && m_owner < 0 && m_gap == 0) && n < budget);
        check(name, (all_empty() && m_owner < 0 && m_gap == 0) ? 1 : 0, 1);
    endtask

    task automatic apply_reset(int hold_cycles);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_out_wvalid", int'(bus.out_wvalid), 0);
        check("rst_out_wlast", int'(bus.out_wlast), 0);
        check("rst_out_wdata", int'(bus.out_wdata), 0);
        check("rst_req_wready", int'(bus.req_wready), 0);
        clear_stim();
        model_reset();
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one status entry per cycle, one transaction entry per output handshake.
    always @(negedge clk) begin
        st_t s;
        tx_t t;
        if (rst_n) begin
            if (st_q.size() == 0) begin
                check("status_entry_present", st_q.size(), 1);
            end else begin
                s = st_q.pop_front();
                check("busy", int'(busy), s.busy);
                check("out_wvalid", int'(bus.out_wvalid), s.vld);
                check("grant_id", int'(grant_id), s.gid);
                check("req_wready", int'(bus.req_wready), s.rdy);
            end
            if (bus.out_wvalid && bus.out_wready) begin
                if (tx_q.size() == 0) begin
                    check("tx_entry_present", tx_q.size(), 1);
                end else begin
                    t = tx_q.pop_front();
                    check("tx_cycle", cyc, t.cyc);
                    check("tx_data", int'(bus.out_wdata), t.data);
                    check("tx_last", int'(bus.out_wlast), t.last);
                end
            end
        end
    end

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cyc     = 0;
        rdy     = 1'b1;
        rdy_pct = 0;
        clear_stim();
        model_reset();
        apply_reset(2);

        // Single requester 1, three-byte frame.
        add_byte(1, 8'hA5, 1'b0, 0);
        add_byte(1, 8'h5A, 1'b0, 0);
        add_byte(1, 8'hFF, 1'b1, 0);
        run_drain("drain_single", 60);

        // All four requesters from reset, two-byte frames, plus a second frame on 0.
        apply_reset(2);
        for (int r = 0; r < N; r++) begin
            add_byte(r, 8'(8'h10 * r + 1), 1'b0, 0);
            add_byte(r, 8'(8'h10 * r + 2), 1'b1, 0);
        end
        add_byte(0, 8'h0E, 1'b0, 0);
        add_byte(0, 8'h0F, 1'b1, 0);
        run_drain("drain_all4", 200);

        // Requester 2 pauses 10 cycles mid-frame while 0 waits; then again with 3 waiting.
        add_byte(2, 8'h21, 1'b0, 0);
        add_byte(2, 8'h22, 1'b0, 10);
        add_byte(2, 8'h23, 1'b1, 0);
        add_byte(0, 8'h01, 1'b0, 0);
        add_byte(0, 8'h02, 1'b1, 0);
        run_drain("drain_pause_wrap", 200);
        add_byte(2, 8'h24, 1'b0, 0);
        add_byte(2, 8'h25, 1'b1, 10);
        add_byte(3, 8'h31, 1'b1, 0);
        add_byte(0, 8'h03, 1'b1, 0);
        run_drain("drain_pause_next", 200);

        // Back-to-back single-byte frames on one requester.
        for (int b = 0; b < 3; b++) add_byte(1, 8'(8'hC0 + b), 1'b1, 0);
        run_drain("drain_b2b", 200);

        // SPI ready stalls for 7 cycles on the second byte.
        add_byte(3, 8'h3A, 1'b0, 0);
        add_byte(3, 8'h3B, 1'b0, 0);
        add_byte(3, 8'h3C, 1'b1, 0);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        repeat (7) rdy_q.push_back(1'b0);
        run_drain("drain_stall", 200);

        // Reset during a frame from 3 with the pointer away from 0.
        add_byte(1, 8'h1A, 1'b1, 0);
        run_drain("drain_pre_reset", 100);
        for (int b = 0; b < 5; b++) add_byte(3, 8'(8'h90 + b), (b == 4), 0);
        repeat (4) step();
        apply_reset(3);
        add_byte(1, 8'h1B, 1'b0, 0);
        add_byte(1, 8'h1C, 1'b1, 0);
        add_byte(3, 8'h3D, 1'b1, 0);
        run_drain("drain_post_reset", 200);

        // Randomized traffic with random ready throttling and mid-frame pauses.
        rdy_pct = 30;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(9) == 0) begin
                int r;
                r = $urandom_range(N - 1);
                if (fq[r].size() < 8) add_random_frame(r);
            end
            step();
        end
        rdy_pct = 0;
        run_drain("drain_random", 3000);

        #1;
        check("tx_left_over", tx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
